// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore link balancer.
//   bsg_link_bal_state_e : balancer control state (RUN / QUIESCE)
//   safe_clog2           : index width helper that never returns 0
package bsg_manycore_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        QUIESCE = 1'b1
    } bsg_link_bal_state_e;

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_manycore_link_balancer_merge.sv
// RX merge path: round-robin arbitration over the per-link RX channels into
// a small FIFO that feeds the core RX stream.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   link_v_i/data_i     : per-link RX valid / payload
//   link_ready_and_o    : one-hot grant, only while the FIFO has room
//   core_v_o/data_o     : FIFO head towards the core
//   core_ready_and_i    : core accepts the FIFO head
module bsg_manycore_link_balancer_merge
    import bsg_manycore_pkg::*;
#(
    parameter int unsigned num_links_p  = 2,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned els_p        = 2
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_links_p-1:0]                   link_v_i,
    input  logic [num_links_p-1:0][data_width_p-1:0] link_data_i,
    output logic [num_links_p-1:0]                   link_ready_and_o,
    output logic                                     core_v_o,
    output logic [data_width_p-1:0]                  core_data_o,
    input  logic                                     core_ready_and_i
);

    localparam int unsigned ptr_w_lp  = safe_clog2(num_links_p);
    localparam int unsigned addr_w_lp = safe_clog2(els_p);
    localparam int unsigned cnt_w_lp  = $clog2(els_p + 1);

    logic [ptr_w_lp-1:0]                 arb_ptr_r;
    logic [els_p-1:0][data_width_p-1:0]  mem_r;
    logic [addr_w_lp-1:0]                wr_ptr_r;
    logic [addr_w_lp-1:0]                rd_ptr_r;
    logic [cnt_w_lp-1:0]                 count_r;

    logic                full;
    logic                grant_v;
    logic [ptr_w_lp-1:0] grant_idx;
    logic [ptr_w_lp-1:0] scan_idx;
    int unsigned         scan;
    logic                enq;
    logic                deq;

    // Fullness ignores a same-cycle dequeue: a full FIFO never grants.
    assign full     = (count_r == cnt_w_lp'(els_p));
    assign core_v_o = (count_r != '0);
    assign core_data_o = mem_r[rd_ptr_r];
    assign deq      = core_v_o & core_ready_and_i;
    assign enq      = grant_v & ~full & ~reset_i;

    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        scan      = 0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < num_links_p; k++) begin
            scan = 32'(arb_ptr_r) + k;
            if (scan >= num_links_p) scan = scan - num_links_p;
            scan_idx = ptr_w_lp'(scan);
            if (!grant_v && link_v_i[scan_idx]) begin
                grant_v   = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        link_ready_and_o = '0;
        if (enq) link_ready_and_o[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            arb_ptr_r <= '0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
        end else begin
            if (enq) begin
                arb_ptr_r <= (grant_idx == ptr_w_lp'(num_links_p - 1)) ? '0 : grant_idx + 1'b1;
                wr_ptr_r  <= (wr_ptr_r == addr_w_lp'(els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
            end
            if (deq) begin
                rd_ptr_r <= (rd_ptr_r == addr_w_lp'(els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= link_data_i[grant_idx];
    end

endmodule

// File: rtl/bsg_manycore_link_balancer.sv
// Spreads a core TX stream over several SDR link channels and merges their
// RX streams back into one core RX stream.
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   en_mask_i, mode_i     : per-link enable; 0 = round-robin stripe, 1 = pinned
//   core_v_i/data_i/ready_and_o  : core TX stream
//   core_v_o/data_o/ready_and_i  : core RX stream
//   link_v_o/data_o/ready_and_i  : per-link TX
//   link_v_i/data_i/ready_and_o  : per-link RX
//   quiesce_o             : high while TX is drained after a config change
// Optional: define BSG_MANYCORE_LINK_BALANCER_STATS_EN to add per-link
// 32-bit transfer counters tx_count_o / rx_count_o.
module bsg_manycore_link_balancer
    import bsg_manycore_pkg::*;
#(
    parameter int unsigned num_links_p      = 2,
    parameter int unsigned data_width_p     = 32,
    parameter int unsigned quiesce_cycles_p = 16,
    parameter int unsigned rx_fifo_els_p    = 2
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_links_p-1:0]                   en_mask_i,
    input  logic                                     mode_i,
    input  logic                                     core_v_i,
    input  logic [data_width_p-1:0]                  core_data_i,
    output logic                                     core_ready_and_o,
    output logic                                     core_v_o,
    output logic [data_width_p-1:0]                  core_data_o,
    input  logic                                     core_ready_and_i,
    output logic [num_links_p-1:0]                   link_v_o,
    output logic [num_links_p-1:0][data_width_p-1:0] link_data_o,
    input  logic [num_links_p-1:0]                   link_ready_and_i,
    input  logic [num_links_p-1:0]                   link_v_i,
    input  logic [num_links_p-1:0][data_width_p-1:0] link_data_i,
    output logic [num_links_p-1:0]                   link_ready_and_o,
    output logic                                     quiesce_o
`ifdef BSG_MANYCORE_LINK_BALANCER_STATS_EN
    ,
    output logic [num_links_p-1:0][31:0]             tx_count_o,
    output logic [num_links_p-1:0][31:0]             rx_count_o
`endif
);

    localparam int unsigned ptr_w_lp = safe_clog2(num_links_p);
    localparam int unsigned cnt_w_lp = safe_clog2(quiesce_cycles_p);

    bsg_link_bal_state_e  state_r, state_n;
    logic [cnt_w_lp-1:0]  qcnt_r, qcnt_n;
    logic [num_links_p-1:0] en_mask_r;
    logic                 mode_r;
    logic                 cfg_valid_r;
    logic                 cfg_change;
    logic [ptr_w_lp-1:0]  rr_ptr_r;

    logic                 tx_found;
    logic [ptr_w_lp-1:0]  tx_target;
    logic [ptr_w_lp-1:0]  scan_idx;
    int unsigned          scan;
    logic                 tx_fire;

    // The first cycle after reset only loads the config copies, so a
    // non-zero mask held through reset does not extend the drain interval.
    assign cfg_change = cfg_valid_r & ((en_mask_i != en_mask_r) | (mode_i != mode_r));
    assign quiesce_o  = (state_r == QUIESCE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_mask_r   <= '0;
            mode_r      <= 1'b0;
            cfg_valid_r <= 1'b0;
        end else begin
            en_mask_r   <= en_mask_i;
            mode_r      <= mode_i;
            cfg_valid_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= QUIESCE;
            qcnt_r  <= '0;
        end else begin
            state_r <= state_n;
            qcnt_r  <= qcnt_n;
        end
    end

    always_comb begin
        state_n = state_r;
        qcnt_n  = qcnt_r;
        case (state_r)
            RUN: begin
                if (cfg_change) begin
                    state_n = QUIESCE;
                    qcnt_n  = '0;
                end
            end
            QUIESCE: begin
                if (cfg_change) begin
                    qcnt_n = '0;
                end else if (qcnt_r == cnt_w_lp'(quiesce_cycles_p - 1)) begin
                    state_n = RUN;
                    qcnt_n  = '0;
                end else begin
                    qcnt_n = qcnt_r + 1'b1;
                end
            end
            default: begin
                state_n = QUIESCE;
                qcnt_n  = '0;
            end
        endcase
    end

    // Stripe: first enabled and ready link from rr_ptr upward.
    // Pinned: lowest enabled link regardless of readiness.
    always_comb begin
        tx_found  = 1'b0;
        tx_target = '0;
        scan      = 0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < num_links_p; k++) begin
            scan = mode_i ? k : 32'(rr_ptr_r) + k;
            if (scan >= num_links_p) scan = scan - num_links_p;
            scan_idx = ptr_w_lp'(scan);
            if (!tx_found && en_mask_i[scan_idx] && (mode_i || link_ready_and_i[scan_idx])) begin
                tx_found  = 1'b1;
                tx_target = scan_idx;
            end
        end
    end

    always_comb begin
        link_v_o         = '0;
        core_ready_and_o = 1'b0;
        if (state_r == RUN && tx_found) begin
            link_v_o[tx_target] = core_v_i;
            core_ready_and_o    = link_ready_and_i[tx_target];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < num_links_p; i++) link_data_o[i] = core_data_i;
    end

    assign tx_fire = core_v_i & core_ready_and_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_r <= '0;
        end else if (tx_fire && !mode_i) begin
            rr_ptr_r <= (tx_target == ptr_w_lp'(num_links_p - 1)) ? '0 : tx_target + 1'b1;
        end
    end

    bsg_manycore_link_balancer_merge #(
        .num_links_p  (num_links_p),
        .data_width_p (data_width_p),
        .els_p        (rx_fifo_els_p)
    ) merge (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .link_v_i         (link_v_i),
        .link_data_i      (link_data_i),
        .link_ready_and_o (link_ready_and_o),
        .core_v_o         (core_v_o),
        .core_data_o      (core_data_o),
        .core_ready_and_i (core_ready_and_i)
    );

`ifdef BSG_MANYCORE_LINK_BALANCER_STATS_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_count_o <= '0;
            rx_count_o <= '0;
        end else begin
            for (int unsigned i = 0; i < num_links_p; i++) begin
                if (link_v_o[i] && link_ready_and_i[i]) tx_count_o[i] <= tx_count_o[i] + 32'd1;
                if (link_v_i[i] && link_ready_and_o[i]) rx_count_o[i] <= rx_count_o[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_link_balancer.sv
// Directed bench for bsg_manycore_link_balancer with 4 links, 16-cycle drain
// and a 2-entry RX FIFO: table-driven TX routing vectors plus hand-written
// sequences for the drain window, RX contention and reset.
module tb_bsg_manycore_link_balancer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic               clk;
    logic               reset_i;
    logic [N-1:0]       en_mask_i;
    logic               mode_i;
    logic               core_v_i;
    logic [W-1:0]       core_data_i;
    logic               core_ready_and_o;
    logic               core_v_o;
    logic [W-1:0]       core_data_o;
    logic               core_ready_and_i;
    logic [N-1:0]       link_v_o;
    logic [N-1:0][W-1:0] link_data_o;
    logic [N-1:0]       link_ready_and_i;
    logic [N-1:0]       link_v_i;
    logic [N-1:0][W-1:0] link_data_i;
    logic [N-1:0]       link_ready_and_o;
    logic               quiesce_o;
`ifdef BSG_MANYCORE_LINK_BALANCER_STATS_EN
    logic [N-1:0][31:0] tx_count_o;
    logic [N-1:0][31:0] rx_count_o;
`endif

    int checks = 0;
    int errors = 0;

    bsg_manycore_link_balancer #(
        .num_links_p      (N),
        .data_width_p     (W),
        .quiesce_cycles_p (16),
        .rx_fifo_els_p    (2)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .en_mask_i        (en_mask_i),
        .mode_i           (mode_i),
        .core_v_i         (core_v_i),
        .core_data_i      (core_data_i),
        .core_ready_and_o (core_ready_and_o),
        .core_v_o         (core_v_o),
        .core_data_o      (core_data_o),
        .core_ready_and_i (core_ready_and_i),
        .link_v_o         (link_v_o),
        .link_data_o      (link_data_o),
        .link_ready_and_i (link_ready_and_i),
        .link_v_i         (link_v_i),
        .link_data_i      (link_data_i),
        .link_ready_and_o (link_ready_and_o),
        .quiesce_o        (quiesce_o)
`ifdef BSG_MANYCORE_LINK_BALANCER_STATS_EN
        ,
        .tx_count_o       (tx_count_o),
        .rx_count_o       (rx_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       mode;
        logic [3:0] mask;
        logic [3:0] ready;
        logic       cv;
        logic [3:0] exp_v;
        logic       exp_rdy;
    } tx_vec_t;

    tx_vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps past the config-change edge, then waits (bounded) for RUN.
    task automatic wait_run();
        int n;
        n = 0;
        step();
        while (quiesce_o === 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("wait_run", {63'd0, quiesce_o}, 64'd0);
    endtask

    logic [3:0] exp_g  [9];
    logic       exp_cv [9];
    logic [31:0] exp_d [9];
    logic [3:0] rx_pend;
    int         lane;

    initial begin
        vecs[0]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1};
        vecs[1]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1};
        vecs[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1};
        vecs[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1};
        vecs[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1};
        vecs[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1};
        vecs[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1};
        vecs[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1};
        vecs[8]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1};
        vecs[9]  = '{1'b0, 4'hF, 4'hC, 1'b1, 4'h4, 1'b1};
        vecs[10] = '{1'b0, 4'hF, 4'h7, 1'b1, 4'h1, 1'b1};
        vecs[11] = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0};
        vecs[12] = '{1'b0, 4'hF, 4'h8, 1'b1, 4'h8, 1'b1};
        vecs[13] = '{1'b0, 4'hB, 4'hE, 1'b1, 4'h2, 1'b1};
        vecs[14] = '{1'b0, 4'hB, 4'hF, 1'b1, 4'h8, 1'b1};
        vecs[15] = '{1'b0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0};
        vecs[16] = '{1'b1, 4'h6, 4'hD, 1'b1, 4'h2, 1'b0};
        vecs[17] = '{1'b1, 4'h6, 4'h2, 1'b1, 4'h2, 1'b1};
        vecs[18] = '{1'b1, 4'h6, 4'hF, 1'b0, 4'h0, 1'b1};
        vecs[19] = '{1'b1, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0};

        exp_g  = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h0};
        exp_cv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d  = '{32'h0, 32'hD000_0000, 32'hD000_0000, 32'hD000_0000, 32'hD000_0000,
                   32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'h0};

        reset_i          = 1'b1;
        en_mask_i        = 4'hF;
        mode_i           = 1'b0;
        core_v_i         = 1'b0;
        core_data_i      = '0;
        core_ready_and_i = 1'b0;
        link_ready_and_i = 4'hF;
        link_v_i         = 4'hF;
        for (int i = 0; i < N; i++) link_data_i[i] = 32'hD000_0000 + 32'(i);
        repeat (3) step();

        core_v_i = 1'b1;
        #1;
        chk("rst_core_ready", {63'd0, core_ready_and_o}, 64'd0);
        chk("rst_core_v", {63'd0, core_v_o}, 64'd0);
        chk("rst_link_v", {60'd0, link_v_o}, 64'd0);
        chk("rst_link_ready", {60'd0, link_ready_and_o}, 64'd0);
        chk("rst_quiesce", {63'd0, quiesce_o}, 64'd1);
        core_v_i = 1'b0;
        link_v_i = 4'h0;
        step();
        reset_i = 1'b0;
        wait_run();

        // TX routing table.
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].mask !== en_mask_i || vecs[i].mode !== mode_i) begin
                core_v_i  = 1'b0;
                en_mask_i = vecs[i].mask;
                mode_i    = vecs[i].mode;
                wait_run();
            end
            link_ready_and_i = vecs[i].ready;
            core_v_i         = vecs[i].cv;
            core_data_i      = 32'hA000_0000 + 32'(i);
            #1;
            chk($sformatf("vec%0d_link_v", i), {60'd0, link_v_o}, {60'd0, vecs[i].exp_v});
            chk($sformatf("vec%0d_core_ready", i), {63'd0, core_ready_and_o}, {63'd0, vecs[i].exp_rdy});
            if (vecs[i].exp_v != 4'h0) begin
                lane = 0;
                for (int k = N - 1; k >= 0; k--) if (vecs[i].exp_v[k]) lane = k;
                chk($sformatf("vec%0d_data", i), {32'd0, link_data_o[lane]}, {32'd0, core_data_i});
            end
            step();
        end

        // Mask 0011 -> 0001 mid-stream: drain window with RX still live.
        core_v_i  = 1'b0;
        en_mask_i = 4'h3;
        mode_i    = 1'b0;
        wait_run();
        en_mask_i        = 4'h1;
        core_v_i         = 1'b1;
        link_ready_and_i = 4'hF;
        core_ready_and_i = 1'b1;
        #1;
        chk("mask_chg_T_run", {63'd0, quiesce_o}, 64'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 3) begin
                link_v_i       = 4'h8;
                link_data_i[3] = 32'hBEEF_0003;
            end
            if (k == 4) link_v_i = 4'h0;
            #1;
            chk($sformatf("win%0d_quiesce", k), {63'd0, quiesce_o}, 64'd1);
            chk($sformatf("win%0d_link_v", k), {60'd0, link_v_o}, 64'd0);
            chk($sformatf("win%0d_core_ready", k), {63'd0, core_ready_and_o}, 64'd0);
            if (k == 3) chk("win_rx_grant", {60'd0, link_ready_and_o}, 64'h8);
            if (k == 4) begin
                chk("win_rx_v", {63'd0, core_v_o}, 64'd1);
                chk("win_rx_data", {32'd0, core_data_o}, 64'hBEEF_0003);
            end
        end
        step();
        chk("win_end_quiesce", {63'd0, quiesce_o}, 64'd0);
        chk("win_end_link_v", {60'd0, link_v_o}, 64'h1);
        step();
        core_v_i = 1'b0;

        // RX contention with backpressure, then release.
        for (int i = 0; i < N; i++) link_data_i[i] = 32'hD000_0000 + 32'(i);
        rx_pend = 4'hF;
        step();
        for (int c = 0; c < 9; c++) begin
            core_ready_and_i = (c >= 4);
            link_v_i         = rx_pend;
            #1;
            chk($sformatf("rx%0d_grant", c), {60'd0, link_ready_and_o}, {60'd0, exp_g[c]});
            chk($sformatf("rx%0d_core_v", c), {63'd0, core_v_o}, {63'd0, exp_cv[c]});
            if (exp_cv[c]) chk($sformatf("rx%0d_data", c), {32'd0, core_data_o}, {32'd0, exp_d[c]});
            rx_pend = rx_pend & ~exp_g[c];
            step();
        end
        link_v_i = 4'h0;

        // Reset pulsed mid-burst.
        en_mask_i = 4'hF;
        wait_run();
        core_v_i         = 1'b1;
        core_ready_and_i = 1'b0;
        link_v_i         = 4'h1;
        #1;
        chk("burst_ptr1_link_v", {60'd0, link_v_o}, 64'h2);
        step();
        #1;
        chk("burst_ptr2_link_v", {60'd0, link_v_o}, 64'h4);
        chk("burst_fifo_v", {63'd0, core_v_o}, 64'd1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("midrst_core_ready", {63'd0, core_ready_and_o}, 64'd0);
        chk("midrst_core_v", {63'd0, core_v_o}, 64'd0);
        chk("midrst_link_v", {60'd0, link_v_o}, 64'd0);
        chk("midrst_link_ready", {60'd0, link_ready_and_o}, 64'd0);
        chk("midrst_quiesce", {63'd0, quiesce_o}, 64'd1);
        step();
        step();
        reset_i  = 1'b0;
        link_v_i = 4'h0;
        #1;
        chk("postrst_quiesce0", {63'd0, quiesce_o}, 64'd1);
        chk("postrst_fifo_empty", {63'd0, core_v_o}, 64'd0);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("postrst_quiesce%0d", k), {63'd0, quiesce_o}, 64'd1);
        end
        step();
        chk("postrst_run", {63'd0, quiesce_o}, 64'd0);
        chk("postrst_ptr0_link_v", {60'd0, link_v_o}, 64'h1);
        chk("postrst_core_ready", {63'd0, core_ready_and_o}, 64'd1);
        core_v_i = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
